// File: rtl/bd_word_arbiter.sv
// Round-robin arbiter onto the single unencoded BD-word channel, with burst
// locking for multi-word programming leaves and invalid-leaf filtering.
module bd_word_arbiter #(
  parameter int unsigned NIN       = 3,
  parameter int unsigned NCODE     = 6,
  parameter int unsigned NPAYLOAD  = 20,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned NDROP     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NIN-1:0]           in_v,
  output logic [NIN-1:0]           in_a,
  input  logic [NIN*NCODE-1:0]     in_leaf_code,
  input  logic [NIN*NPAYLOAD-1:0]  in_payload,
  output logic                     enc_out_v,
  output logic [NCODE-1:0]         enc_out_leaf_code,
  output logic [NPAYLOAD-1:0]      enc_out_payload,
  input  logic                     enc_out_a,
  output logic [2:0]               grant,
  output logic                     locked,
  output logic [NDROP-1:0]         drop_count
);

  localparam int unsigned GW = 3;
  localparam int unsigned SW = GW + 1;
  localparam int unsigned RW = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;

  localparam logic [NCODE-1:0] LEAF_INVALID_MIN = NCODE'(34);
  localparam logic [NCODE-1:0] LEAF_BURST_LO    = NCODE'(26);
  localparam logic [NCODE-1:0] LEAF_BURST_HI    = NCODE'(29);

  typedef enum logic [0:0] {S_IDLE, S_LOCKED} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       rr_q, rr_d;
  logic [GW-1:0]       owner_q, owner_d;
  logic [RW-1:0]       rem_q, rem_d;
  logic                full_q, full_d;
  logic [NCODE-1:0]    leaf_q, leaf_d;
  logic [NPAYLOAD-1:0] payload_q, payload_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [NDROP-1:0]    drop_q, drop_d;

  logic                found;
  logic [GW-1:0]       winner;
  logic [GW-1:0]       winner_next;
  logic [SW-1:0]       scan_idx;
  logic [NCODE-1:0]    win_code;
  logic [NPAYLOAD-1:0] win_payload;
  logic                is_invalid;
  logic                is_burst;
  logic                can_load;
  logic                ack;
  logic                load;

  // Winner selection: owner only while locked, otherwise rotate from rr.
  always_comb begin
    found    = 1'b0;
    winner   = owner_q;
    scan_idx = '0;
    if (state_q == S_LOCKED) begin
      for (int unsigned j = 0; j < NIN; j++) begin
        if (GW'(j) == owner_q) found = in_v[j];
      end
    end else begin
      for (int unsigned k = 0; k < NIN; k++) begin
        scan_idx = SW'(rr_q) + SW'(k);
        if (scan_idx >= SW'(NIN)) scan_idx = scan_idx - SW'(NIN);
        for (int unsigned j = 0; j < NIN; j++) begin
          if (!found && in_v[j] && (SW'(j) == scan_idx)) begin
            found  = 1'b1;
            winner = GW'(j);
          end
        end
      end
    end
  end

  // Winner word mux, classification and handshake.
  always_comb begin
    win_code    = '0;
    win_payload = '0;
    for (int unsigned j = 0; j < NIN; j++) begin
      if (GW'(j) == winner) begin
        win_code    = in_leaf_code[j*NCODE +: NCODE];
        win_payload = in_payload[j*NPAYLOAD +: NPAYLOAD];
      end
    end
    is_invalid  = (win_code >= LEAF_INVALID_MIN);
    is_burst    = (win_code >= LEAF_BURST_LO) && (win_code <= LEAF_BURST_HI);
    can_load    = !full_q || enc_out_a;
    // Invalid words are swallowed regardless of output backpressure.
    ack         = reset && found && (is_invalid || can_load);
    load        = ack && !is_invalid;
    winner_next = (winner == GW'(NIN - 1)) ? '0 : winner + GW'(1);
    in_a        = '0;
    for (int unsigned j = 0; j < NIN; j++) begin
      if (GW'(j) == winner) in_a[j] = ack;
    end
  end

  // Next-state logic for FSM, output register and counters.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    rem_d     = rem_q;
    full_d    = full_q;
    leaf_d    = leaf_q;
    payload_d = payload_q;
    grant_d   = grant_q;
    drop_d    = drop_q;

    case (state_q)
      S_IDLE: begin
        if (ack) begin
          if (!is_invalid && is_burst) begin
            owner_d = winner;
            rem_d   = RW'(BURST_LEN - 1);
            state_d = S_LOCKED;
          end else begin
            rr_d = winner_next;
          end
        end
      end
      S_LOCKED: begin
        // Every owner word consumes a burst slot, even a dropped one.
        if (ack) begin
          if (rem_q == RW'(1)) begin
            state_d = S_IDLE;
            rr_d    = winner_next;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - RW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (full_q && enc_out_a) full_d = 1'b0;
    if (load) begin
      full_d    = 1'b1;
      leaf_d    = win_code;
      payload_d = win_payload;
    end
    if (ack) grant_d = winner;
    if (ack && is_invalid && (drop_q != '1)) drop_d = drop_q + NDROP'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      owner_q   <= '0;
      rem_q     <= '0;
      full_q    <= 1'b0;
      leaf_q    <= '0;
      payload_q <= '0;
      grant_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      rem_q     <= rem_d;
      full_q    <= full_d;
      leaf_q    <= leaf_d;
      payload_q <= payload_d;
      grant_q   <= grant_d;
      drop_q    <= drop_d;
    end
  end

  assign enc_out_v         = full_q;
  assign enc_out_leaf_code = leaf_q;
  assign enc_out_payload   = payload_q;
  assign grant             = grant_q;
  assign locked            = (state_q == S_LOCKED);
  assign drop_count        = drop_q;

endmodule

// File: tb/tb_bd_word_arbiter.sv
// Scoreboard bench for bd_word_arbiter: per-requester word queues feed the
// DUT, expected encoder words are queued by the stimulus and popped by a monitor.
module tb_bd_word_arbiter;

  localparam int unsigned NIN   = 3;
  localparam int unsigned NC    = 6;
  localparam int unsigned NP    = 20;
  localparam int unsigned NDROP = 8;

  logic                 clk;
  logic                 reset;
  logic [NIN-1:0]       in_v;
  logic [NIN-1:0]       in_a;
  logic [NIN*NC-1:0]    in_leaf_code;
  logic [NIN*NP-1:0]    in_payload;
  logic                 enc_out_v;
  logic [NC-1:0]        enc_out_leaf_code;
  logic [NP-1:0]        enc_out_payload;
  logic                 enc_a;
  logic [2:0]           grant;
  logic                 locked;
  logic [NDROP-1:0]     drop_count;

  logic [25:0] q0[$];
  logic [25:0] q1[$];
  logic [25:0] q2[$];
  logic [25:0] exp_q[$];

  int checks;
  int failures;

  bd_word_arbiter #(
    .NIN(NIN), .NCODE(NC), .NPAYLOAD(NP), .BURST_LEN(4), .NDROP(NDROP)
  ) dut (
    .clk(clk), .reset(reset),
    .in_v(in_v), .in_a(in_a),
    .in_leaf_code(in_leaf_code), .in_payload(in_payload),
    .enc_out_v(enc_out_v), .enc_out_leaf_code(enc_out_leaf_code),
    .enc_out_payload(enc_out_payload), .enc_out_a(enc_a),
    .grant(grant), .locked(locked), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [25:0] w(input int code, input int pl);
    return {6'(code), 20'(pl)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, expv);
    end
  endtask

  task automatic set_req(input int i, input logic vld, input logic [25:0] wd);
    in_v[i]               = vld;
    in_leaf_code[i*NC +: NC] = wd[25:20];
    in_payload[i*NP +: NP]   = wd[19:0];
  endtask

  // Presents each queue head; pops it once the DUT acknowledged it.
  task automatic driver();
    logic [2:0] fire;
    forever begin
      @(negedge clk);
      fire = in_v & in_a;
      @(posedge clk);
      #1;
      if (fire[0] && q0.size() > 0) void'(q0.pop_front());
      if (fire[1] && q1.size() > 0) void'(q1.pop_front());
      if (fire[2] && q2.size() > 0) void'(q2.pop_front());
      set_req(0, q0.size() > 0, (q0.size() > 0) ? q0[0] : 26'd0);
      set_req(1, q1.size() > 0, (q1.size() > 0) ? q1[0] : 26'd0);
      set_req(2, q2.size() > 0, (q2.size() > 0) ? q2[0] : 26'd0);
    end
  endtask

  task automatic monitor();
    logic [25:0] e;
    forever begin
      @(negedge clk);
      if (reset && enc_out_v && enc_a) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_word unexpected got=%h", {enc_out_leaf_code, enc_out_payload});
        end else begin
          e = exp_q.pop_front();
          if ({enc_out_leaf_code, enc_out_payload} !== e) begin
            failures++;
            $display("FAIL out_word got=%h exp=%h", {enc_out_leaf_code, enc_out_payload}, e);
          end
        end
      end
    end
  endtask

  task automatic wait_fire(input logic [2:0] mask, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((in_v & in_a & mask) == 3'b000) && n < 50);
    if ((in_v & in_a & mask) == 3'b000) begin
      checks++;
      failures++;
      $display("FAIL %s timeout got=none exp=accept", name);
    end
  endtask

  task automatic wait_q_empty(input int which, input string name);
    int n;
    int sz;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      sz = (which == 0) ? q0.size() : (which == 1) ? q1.size() : q2.size();
    end while (sz != 0 && n < 400);
    if (sz != 0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout got=%0d exp=0 pending", name, sz);
    end
  endtask

  task automatic wait_drained(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((q0.size() + q1.size() + q2.size() + exp_q.size() != 0 || enc_out_v) && n < 400);
    if (q0.size() + q1.size() + q2.size() + exp_q.size() != 0 || enc_out_v) begin
      checks++;
      failures++;
      $display("FAIL %s timeout got=%0d exp=0 pending", name, exp_q.size());
    end
  endtask

  initial begin
    int vcnt;
    checks = 0;
    failures = 0;
    reset = 1'b0;
    enc_a = 1'b0;
    in_v = '0;
    in_leaf_code = '0;
    in_payload = '0;
    fork
      driver();
      monitor();
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_v", 32'(enc_out_v), 0);
    chk("rst_leaf", 32'(enc_out_leaf_code), 0);
    chk("rst_payload", 32'(enc_out_payload), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_in_a", 32'(in_a), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    enc_a = 1'b1;

    // Fairness: grants 0,1,2,0,1,2, one word per cycle
    @(negedge clk);
    q0.push_back(w(30, 'h00)); q0.push_back(w(30, 'h01));
    q1.push_back(w(30, 'h10)); q1.push_back(w(30, 'h11));
    q2.push_back(w(30, 'h20)); q2.push_back(w(30, 'h21));
    exp_q.push_back(w(30, 'h00)); exp_q.push_back(w(30, 'h10)); exp_q.push_back(w(30, 'h20));
    exp_q.push_back(w(30, 'h01)); exp_q.push_back(w(30, 'h11)); exp_q.push_back(w(30, 'h21));
    wait_fire(3'b111, "fair_first_accept");
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) chk("fair_latency_v", 32'(enc_out_v), 1);
      if (enc_out_v) vcnt++;
    end
    chk("fair_stream_words", 32'(vcnt), 6);
    @(negedge clk);
    chk("fair_end_v", 32'(enc_out_v), 0);
    wait_drained("fair_drain");

    // Burst lock: req0 leaf 26 x4 while req1/req2 stream
    q0.push_back(w(26, 1)); q0.push_back(w(26, 2)); q0.push_back(w(26, 3)); q0.push_back(w(26, 4));
    q1.push_back(w(30, 'h31)); q1.push_back(w(30, 'h32));
    q2.push_back(w(30, 'h41));
    exp_q.push_back(w(26, 1)); exp_q.push_back(w(26, 2));
    exp_q.push_back(w(26, 3)); exp_q.push_back(w(26, 4));
    exp_q.push_back(w(30, 'h31)); exp_q.push_back(w(30, 'h41)); exp_q.push_back(w(30, 'h32));
    wait_fire(3'b001, "burst_start");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("burst_locked", 32'(locked), 1);
      chk("burst_block_req1", 32'(in_a[1]), 0);
    end
    @(negedge clk);
    chk("burst_unlocked", 32'(locked), 0);
    chk("burst_next_req1", 32'(in_a[1]), 1);
    @(negedge clk);
    chk("burst_grant_after", 32'(grant), 1);
    wait_drained("burst_drain");

    // Backpressure with a buffered word
    @(posedge clk); #1;
    enc_a = 1'b0;
    @(negedge clk);
    q0.push_back(w(30, 'h50));
    exp_q.push_back(w(30, 'h50));
    wait_fire(3'b001, "bp_first");
    q1.push_back(w(30, 'h51));
    q2.push_back(w(33, 'h52));
    exp_q.push_back(w(30, 'h51));
    exp_q.push_back(w(33, 'h52));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_a", 32'(in_a), 0);
      chk("bp_v", 32'(enc_out_v), 1);
      chk("bp_payload", 32'(enc_out_payload), 'h50);
    end
    @(posedge clk); #1;
    enc_a = 1'b1;
    @(negedge clk);
    chk("bp_reload_req1", 32'(in_a), 3'b010);
    wait_drained("bp_drain");

    // Invalid leaf dropped under backpressure, counter saturation
    @(posedge clk); #1;
    enc_a = 1'b0;
    @(negedge clk);
    q0.push_back(w(30, 'h60));
    exp_q.push_back(w(30, 'h60));
    wait_fire(3'b001, "inv_load");
    q1.push_back(w(40, 'h99));
    @(negedge clk);
    chk("inv_ack_req1", 32'(in_a), 3'b010);
    chk("inv_drop_before", 32'(drop_count), 0);
    @(negedge clk);
    chk("inv_drop_after", 32'(drop_count), 1);
    chk("inv_hold_payload", 32'(enc_out_payload), 'h60);
    for (int i = 0; i < 254; i++) q1.push_back(w(34 + (i % 30), i));
    wait_q_empty(1, "inv_sat_fill");
    chk("drop_sat_reach", 32'(drop_count), 'hFF);
    q1.push_back(w(63, 5));
    wait_q_empty(1, "inv_sat_extra");
    chk("drop_sat_hold", 32'(drop_count), 'hFF);
    chk("inv_out_v", 32'(enc_out_v), 1);
    chk("inv_out_payload", 32'(enc_out_payload), 'h60);
    @(posedge clk); #1;
    enc_a = 1'b1;
    wait_drained("inv_drain");

    // Stalled burst owner keeps the lock
    q2.push_back(w(28, 'h71)); q2.push_back(w(28, 'h72));
    exp_q.push_back(w(28, 'h71)); exp_q.push_back(w(28, 'h72));
    wait_q_empty(2, "stall_first_half");
    q0.push_back(w(30, 'h80));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_block_req0", 32'(in_a[0]), 0);
      chk("stall_locked", 32'(locked), 1);
    end
    q2.push_back(w(28, 'h73)); q2.push_back(w(28, 'h74));
    exp_q.push_back(w(28, 'h73)); exp_q.push_back(w(28, 'h74));
    exp_q.push_back(w(30, 'h80));
    wait_q_empty(2, "stall_second_half");
    chk("stall_release_locked", 32'(locked), 0);
    chk("stall_release_req0", 32'(in_a[0]), 1);
    wait_drained("stall_drain");

    // Reset in the middle of a burst
    q1.push_back(w(29, 'h91)); q1.push_back(w(29, 'h92));
    exp_q.push_back(w(29, 'h91));
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(in_v[1] && in_a[1] && in_payload[NP +: NP] == 20'h92) && n < 50);
      chk("rmb_second_word_accept", 32'(in_v[1] && in_a[1] && in_payload[NP +: NP] == 20'h92), 1);
    end
    @(posedge clk); #1;
    enc_a = 1'b0;
    @(negedge clk);
    chk("rmb_locked", 32'(locked), 1);
    chk("rmb_buffered", 32'(enc_out_payload), 'h92);
    q0.push_back(w(30, 'hA0));
    q1.push_back(w(30, 'hA1));
    #1;
    reset = 1'b0;
    #1;
    chk("rmb_v_cleared", 32'(enc_out_v), 0);
    chk("rmb_lock_cleared", 32'(locked), 0);
    @(negedge clk);
    chk("rmb_in_a_in_reset", 32'(in_a), 0);
    exp_q.push_back(w(30, 'hA0));
    exp_q.push_back(w(30, 'hA1));
    @(posedge clk); #1;
    reset = 1'b1;
    enc_a = 1'b1;
    @(negedge clk);
    chk("rmb_first_req0", 32'(in_a), 3'b001);
    wait_drained("rmb_drain");
    chk("final_exp_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bd_word_arbiter.md
# bd_word_arbiter

Round-robin arbiter that shares the single unencoded-BD-word channel into the BD encoder among NIN upstream requesters (host downstream path, spike generators, config sequencer). Multi-word programming leaves (PROG_AMMM, PROG_PAT, PROG_TAT0, PROG_TAT1) are serialized by software into 4 consecutive words, so the arbiter locks the grant for those bursts to prevent interleaving. It also filters out invalid leaf codes and registers its output so the encoder sees a clean, single-stage-buffered stream.

## Interface
- NIN, 3: number of requesters (2..8)
- NCODE, 6: leaf_code width
- NPAYLOAD, 20: payload width
- BURST_LEN, 4: words per multi-word programming leaf
- NDROP, 16: width of invalid-word drop counter
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low (asserted when 0); clears all state
- in_v  in  NIN  per-requester valid
- in_a  out  NIN  per-requester acknowledge (combinational)
- in_leaf_code  in  NIN*NCODE  requester i at bits [i*NCODE +: NCODE]
- in_payload  in  NIN*NPAYLOAD  requester i at bits [i*NPAYLOAD +: NPAYLOAD]
- enc_out  UnencodedBDWordChannel (v, leaf_code, payload out; a in)  to encoder
- grant  out  3  index of requester currently holding or last granted
- locked  out  1  burst lock active
- drop_count  out  NDROP  saturating count of discarded invalid words

## Operation
- Transfer on any channel occurs in a cycle where v and a are both 1.
- Output register (one entry: full flag, leaf_code, payload) drives enc_out; enc_out.v = full. Register may load when empty or when draining in the same cycle (enc_out.a=1).
- States: IDLE, LOCKED. Counter remaining (2 bits for BURST_LEN=4), round-robin pointer rr, lock owner.
- IDLE: winner = first requester with in_v=1 scanning rr, rr+1, ... mod NIN. in_a[winner]=1 iff output register can load; all other in_a=0.
- Invalid leaf (leaf_code >= 34): winner is acked regardless of output register state, word discarded, drop_count++ (saturates at all-ones), rr <- winner+1. Never enters register, never starts a lock.
- Valid non-burst leaf accepted: loaded into register, rr <- winner+1, stay IDLE.
- Burst leaf (codes 26, 27, 28, 29) accepted: loaded, owner <- winner, remaining <- BURST_LEN-1, go LOCKED, rr unchanged.
- LOCKED: only owner eligible; other in_a held 0 even if owner idle. Each accepted owner word (any leaf code; invalid codes dropped and counted but still consume a burst slot) decrements remaining. Acceptance when remaining==1 -> IDLE, rr <- owner+1.
- grant = winner when a transfer occurs, else holds; locked = (state==LOCKED).
- No timeout: a stalled owner holds the lock indefinitely (software guarantees complete bursts).

## Timing
- Reset values: state IDLE, rr=0, remaining=0, owner=0, register empty, enc_out.v=0, enc_out.leaf_code=0, enc_out.payload=0, grant=0, locked=0, drop_count=0; in_a=0 while reset asserted.
- Latency: input accepted on edge N -> enc_out.v=1 with that word after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle with enc_out.a held 1.
- enc_out.v, leaf_code, payload stable while v=1 and a=0.
- in_a depends combinationally on in_v, in_leaf_code, enc_out.a, and state; no combinational path from in_* to enc_out.
- Simultaneous drain and load: both happen, register stays full with new word.
- Reset asserted mid-burst: lock and buffered word discarded immediately (asynchronous); first word after release arbitrates from rr=0.

## Test plan
- Fairness: NIN=3, all in_v=1 with leaf 30 (RI), enc_out.a=1 -> grant sequence 0,1,2,0,1,2; one word out per cycle; first enc_out.v one cycle after first accept.
- Burst lock: req0 sends 4 words leaf 26 payloads 1..4 while req1 and req2 stream leaf 30 -> enc_out shows leaf 26 x4 contiguous, locked=1 for those accepts, then grant 1 next.
- Backpressure: enc_out.a=0 for 5 cycles with word buffered -> all in_a=0 (for valid leaves), enc_out payload unchanged; on a=1 drain and reload same cycle.
- Invalid leaf: req1 sends leaf 40 while enc_out.a=0 -> in_a[1]=1 same cycle, nothing on enc_out, drop_count 0->1; forcing 0xFFFF then another invalid -> stays 0xFFFF.
- Stalled owner: req2 starts leaf 28 burst, drops in_v after 2 words; req0 valid -> in_a[0]=0 until req2 completes remaining 2 words.
- Reset mid-burst: assert reset after 2 of 4 leaf-29 words -> enc_out.v=0, locked=0 immediately; after release req1 and req0 valid -> req0 granted first.
